// File: rtl/brq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | brq_pkg : shared types and pointer helpers for br_retire_queue      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package brq_pkg;

    localparam int BPTAG_W   = 16;
    localparam int PHT_IDX_W = 14;
    localparam int CTR_W     = 2;

    typedef struct packed {
        logic               valid;
        logic               resolved;
        logic               pred;
        logic               actual;
        logic [BPTAG_W-1:0] bptag;
    } brq_entry_t;

    // Returns {wrap bits differ, index bits equal} for two wrap-bit pointers.
    function automatic logic [1:0] ptr_cmp(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          idxw);
        logic [31:0] mask;
        mask    = (32'd1 << idxw) - 32'd1;
        ptr_cmp = {a[idxw] != b[idxw], ((a ^ b) & mask) == 32'd0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/br_retire_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | br_retire_queue_if : fetch / execute / ROB / predictor bundle       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface br_retire_queue_if #(
    parameter int IDXW = 4
) ();
    logic            fetch_br_valid;
    logic [15:0]     fetch_bptag;
    logic            fetch_bptaken;
    logic            brq_full;
    logic [IDXW-1:0] brq_alloc_idx;
    logic            exe_br_valid;
    logic [IDXW-1:0] exe_br_idx;
    logic            exe_br_taken;
    logic            brq_mispredict;
    logic [IDXW-1:0] brq_mispredict_idx;
    logic            rob_br_retire;
    logic            rob_flush;
    logic            brq_head_ready;
    logic            brq_empty;
    logic            brq_ret_branch;
    logic [15:0]     brq_ret_bptag;
    logic            brq_ret_bptaken;

    modport master (
        output fetch_br_valid, fetch_bptag, fetch_bptaken,
        output exe_br_valid, exe_br_idx, exe_br_taken,
        output rob_br_retire, rob_flush,
        input  brq_full, brq_alloc_idx, brq_mispredict, brq_mispredict_idx,
        input  brq_head_ready, brq_empty,
        input  brq_ret_branch, brq_ret_bptag, brq_ret_bptaken
    );

    modport slave (
        input  fetch_br_valid, fetch_bptag, fetch_bptaken,
        input  exe_br_valid, exe_br_idx, exe_br_taken,
        input  rob_br_retire, rob_flush,
        output brq_full, brq_alloc_idx, brq_mispredict, brq_mispredict_idx,
        output brq_head_ready, brq_empty,
        output brq_ret_branch, brq_ret_bptag, brq_ret_bptaken
    );
endinterface
`default_nettype wire

// File: rtl/brq_ptr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | brq_ptr : wrap-bit queue pointer with increment and clear           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module brq_ptr #(
    parameter int W = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc_i,
    input  wire logic         clr_i,
    output logic [W-1:0]      ptr_o
);
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Clear dominates so a flush wins over a same-cycle increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)
            ptr_d = '0;
        else if (inc_i)
            ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;
endmodule
`default_nettype wire

// File: rtl/br_retire_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | br_retire_queue : program-ordered in-flight branch queue feeding   |
// | predictor training at ROB retire.                     Rev 1.0      |
// +--------------------------------------------------------------------+
module br_retire_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDXW  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    br_retire_queue_if.slave  bus
);
    localparam int PW = IDXW + 1;

    logic [PW-1:0]      head_q;
    logic [PW-1:0]      tail_q;
    logic [DEPTH-1:0]   valid_q,    valid_d;
    logic [DEPTH-1:0]   resolved_q, resolved_d;
    logic [DEPTH-1:0]   pred_q;
    logic [DEPTH-1:0]   actual_q;
    logic [BPTAG_W-1:0] bptag_q [DEPTH];
    logic               mispredict_q;
    logic [IDXW-1:0]    mispredict_idx_q;

    logic [IDXW-1:0]    w_head_idx;
    logic [IDXW-1:0]    w_tail_idx;
    logic [1:0]         w_cmp;
    logic               w_full;
    logic               w_empty;
    logic               w_head_ready;
    logic               w_do_alloc;
    logic               w_do_res;
    logic               w_do_ret;
    logic               w_mispred;
    brq_entry_t         w_head;

    assign w_head_idx = head_q[IDXW-1:0];
    assign w_tail_idx = tail_q[IDXW-1:0];
    assign w_cmp      = ptr_cmp(32'(head_q), 32'(tail_q), IDXW);
    assign w_full     = w_cmp[0] &  w_cmp[1];
    assign w_empty    = w_cmp[0] & ~w_cmp[1];

    assign w_head = '{valid:    valid_q[w_head_idx],
                      resolved: resolved_q[w_head_idx],
                      pred:     pred_q[w_head_idx],
                      actual:   actual_q[w_head_idx],
                      bptag:    bptag_q[w_head_idx]};

    assign w_head_ready = w_head.valid & w_head.resolved;
    assign w_do_alloc   = bus.fetch_br_valid & ~w_full & ~bus.rob_flush;
    assign w_do_res     = bus.exe_br_valid & ~bus.rob_flush
                        & valid_q[bus.exe_br_idx] & ~resolved_q[bus.exe_br_idx];
    // Retire is honoured even under flush so the mispredicting branch still trains.
    assign w_do_ret     = bus.rob_br_retire & w_head_ready;
    assign w_mispred    = w_do_res & (bus.exe_br_taken != pred_q[bus.exe_br_idx]);

    brq_ptr #(.W(PW)) u_head (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_do_ret),
        .clr_i (bus.rob_flush),
        .ptr_o (head_q)
    );

    brq_ptr #(.W(PW)) u_tail (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_do_alloc),
        .clr_i (bus.rob_flush),
        .ptr_o (tail_q)
    );

    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        if (bus.rob_flush) begin
            valid_d    = '0;
            resolved_d = '0;
        end else begin
            if (w_do_alloc) begin
                valid_d[w_tail_idx]    = 1'b1;
                resolved_d[w_tail_idx] = 1'b0;
            end
            if (w_do_res)
                resolved_d[bus.exe_br_idx] = 1'b1;
            if (w_do_ret) begin
                valid_d[w_head_idx]    = 1'b0;
                resolved_d[w_head_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q          <= '0;
            resolved_q       <= '0;
            mispredict_q     <= 1'b0;
            mispredict_idx_q <= '0;
        end else begin
            valid_q      <= valid_d;
            resolved_q   <= resolved_d;
            mispredict_q <= w_mispred;
            if (w_mispred)
                mispredict_idx_q <= bus.exe_br_idx;
        end
    end

    // Payload fields are qualified by valid/resolved, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_do_alloc) begin
            bptag_q[w_tail_idx] <= bus.fetch_bptag;
            pred_q[w_tail_idx]  <= bus.fetch_bptaken;
        end
        if (w_do_res)
            actual_q[bus.exe_br_idx] <= bus.exe_br_taken;
    end

    assign bus.brq_full           = w_full;
    assign bus.brq_empty          = w_empty;
    assign bus.brq_alloc_idx      = w_tail_idx;
    assign bus.brq_head_ready     = w_head_ready;
    assign bus.brq_mispredict     = mispredict_q;
    assign bus.brq_mispredict_idx = mispredict_idx_q;
    assign bus.brq_ret_branch     = w_do_ret;
    assign bus.brq_ret_bptag      = w_head_ready ? w_head.bptag : '0;
    assign bus.brq_ret_bptaken    = w_head_ready & w_head.actual;
endmodule
`default_nettype wire

// File: tb/tb_br_retire_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_br_retire_queue : randomized bench with queue-based reference    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_br_retire_queue;
    localparam int DEPTH = 16;
    localparam int IDXW  = 4;

    typedef struct {
        logic [15:0] tag;
        bit          pred;
        bit          act;
        bit          res;
    } ment_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ment_t mq[$];
    int    m_head;
    bit    m_mp;
    int    m_mp_idx;

    br_retire_queue_if #(.IDXW(IDXW)) bif ();

    br_retire_queue #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bif.fetch_br_valid = 1'b0;
        bif.fetch_bptag    = '0;
        bif.fetch_bptaken  = 1'b0;
        bif.exe_br_valid   = 1'b0;
        bif.exe_br_idx     = '0;
        bif.exe_br_taken   = 1'b0;
        bif.rob_br_retire  = 1'b0;
        bif.rob_flush      = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_head   = 0;
        m_mp     = 1'b0;
        m_mp_idx = 0;
    endtask

    // Expected outputs from the queue contents and current inputs.
    task automatic compare_model();
        int  sz;
        bit  hr;
        bit  rb;
        sz = mq.size();
        hr = (sz > 0) && mq[0].res;
        rb = bif.rob_br_retire && hr;
        chk("empty",      32'(bif.brq_empty),      32'(sz == 0));
        chk("full",       32'(bif.brq_full),       32'(sz == DEPTH));
        chk("alloc_idx",  32'(bif.brq_alloc_idx),  32'((m_head + sz) % DEPTH));
        chk("head_ready", 32'(bif.brq_head_ready), 32'(hr));
        chk("ret_branch", 32'(bif.brq_ret_branch), 32'(rb));
        if (rb) begin
            chk("ret_bptag",   32'(bif.brq_ret_bptag),   32'(mq[0].tag));
            chk("ret_bptaken", 32'(bif.brq_ret_bptaken), 32'(mq[0].act));
        end
        chk("mispredict", 32'(bif.brq_mispredict), 32'(m_mp));
        if (m_mp)
            chk("mispredict_idx", 32'(bif.brq_mispredict_idx), 32'(m_mp_idx));
    endtask

    task automatic model_edge();
        bit    f;
        bit    full;
        bit    ret;
        bit    rok;
        int    k;
        ment_t e;
        f    = bif.rob_flush;
        full = (mq.size() == DEPTH);
        ret  = bif.rob_br_retire && (mq.size() > 0) && mq[0].res;
        k    = (int'(bif.exe_br_idx) - m_head + DEPTH) % DEPTH;
        rok  = 1'b0;
        if (bif.exe_br_valid && !f && k < mq.size())
            rok = !mq[k].res;
        m_mp = 1'b0;
        if (rok) begin
            e      = mq[k];
            m_mp   = (bif.exe_br_taken != e.pred);
            e.res  = 1'b1;
            e.act  = bif.exe_br_taken;
            mq[k]  = e;
            if (m_mp)
                m_mp_idx = int'(bif.exe_br_idx);
        end
        if (f) begin
            mq.delete();
            m_head = 0;
        end else begin
            if (ret) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (bif.fetch_br_valid && !full) begin
                e.tag  = bif.fetch_bptag;
                e.pred = bif.fetch_bptaken;
                e.act  = 1'b0;
                e.res  = 1'b0;
                mq.push_back(e);
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic step();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic alloc(input logic [15:0] tag, input bit pred);
        idle();
        bif.fetch_br_valid = 1'b1;
        bif.fetch_bptag    = tag;
        bif.fetch_bptaken  = pred;
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bif.fetch_br_valid = ($urandom % 3) != 0;
            bif.fetch_bptag    = 16'($urandom);
            bif.fetch_bptaken  = 1'($urandom);
            bif.exe_br_valid   = 1'($urandom);
            if (mq.size() > 0 && ($urandom % 4) != 0)
                bif.exe_br_idx = IDXW'((m_head + int'($urandom % 32'(mq.size()))) % DEPTH);
            else
                bif.exe_br_idx = IDXW'($urandom);
            bif.exe_br_taken   = 1'($urandom);
            bif.rob_br_retire  = 1'($urandom);
            bif.rob_flush      = ($urandom % 40) == 0;
            step();
        end
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        chk("rst_empty",      32'(bif.brq_empty),          32'd1);
        chk("rst_full",       32'(bif.brq_full),           32'd0);
        chk("rst_alloc_idx",  32'(bif.brq_alloc_idx),      32'd0);
        chk("rst_head_ready", 32'(bif.brq_head_ready),     32'd0);
        chk("rst_ret_branch", 32'(bif.brq_ret_branch),     32'd0);
        chk("rst_ret_bptag",  32'(bif.brq_ret_bptag),      32'd0);
        chk("rst_ret_taken",  32'(bif.brq_ret_bptaken),    32'd0);
        chk("rst_mp",         32'(bif.brq_mispredict),     32'd0);
        chk("rst_mp_idx",     32'(bif.brq_mispredict_idx), 32'd0);

        alloc(16'h4001, 1'b0); #1; chk("alloc0_idx", 32'(bif.brq_alloc_idx), 32'd0); step();
        alloc(16'h8002, 1'b1); #1; chk("alloc1_idx", 32'(bif.brq_alloc_idx), 32'd1); step();
        alloc(16'hC003, 1'b1); #1; chk("alloc2_idx", 32'(bif.brq_alloc_idx), 32'd2); step();
        idle();
        chk("three_empty", 32'(bif.brq_empty), 32'd0);
        chk("three_full",  32'(bif.brq_full),  32'd0);

        idle(); bif.exe_br_valid = 1'b1; bif.exe_br_idx = 4'd1; bif.exe_br_taken = 1'b0;
        step();
        chk("mp_pulse", 32'(bif.brq_mispredict),     32'd1);
        chk("mp_idx",   32'(bif.brq_mispredict_idx), 32'd1);
        idle(); bif.exe_br_valid = 1'b1; bif.exe_br_idx = 4'd0; bif.exe_br_taken = 1'b0;
        step();
        chk("mp_one_cycle", 32'(bif.brq_mispredict), 32'd0);

        idle(); bif.rob_br_retire = 1'b1; #1;
        chk("ret0_branch", 32'(bif.brq_ret_branch),  32'd1);
        chk("ret0_bptag",  32'(bif.brq_ret_bptag),   32'h4001);
        chk("ret0_taken",  32'(bif.brq_ret_bptaken), 32'd0);
        step();
        idle(); bif.rob_br_retire = 1'b1; #1;
        chk("ret1_bptag",  32'(bif.brq_ret_bptag),   32'h8002);
        step();
        idle(); bif.rob_br_retire = 1'b1; #1;
        chk("ret_unres",   32'(bif.brq_ret_branch),  32'd0);
        step();
        idle();
        chk("unres_head_kept", 32'(bif.brq_empty), 32'd0);

        for (int i = 0; i < 15; i++) begin
            alloc(16'($urandom), 1'($urandom));
            step();
        end
        idle();
        chk("fill_full",  32'(bif.brq_full),      32'd1);
        chk("fill_tail",  32'(bif.brq_alloc_idx), 32'd2);
        alloc(16'hDEAD, 1'b0); step(); idle();
        chk("over_full",  32'(bif.brq_full),      32'd1);

        idle(); bif.exe_br_valid = 1'b1; bif.exe_br_idx = 4'd2; bif.exe_br_taken = 1'b1;
        step();
        alloc(16'hBEEF, 1'b1); bif.rob_br_retire = 1'b1; #1;
        chk("full_ret_branch", 32'(bif.brq_ret_branch), 32'd1);
        step(); idle();
        chk("full_ret_notfull", 32'(bif.brq_full),      32'd0);
        chk("full_ret_tail",    32'(bif.brq_alloc_idx), 32'd2);

        idle(); bif.exe_br_valid = 1'b1; bif.exe_br_idx = 4'd3; bif.exe_br_taken = mq[0].pred;
        step();
        alloc(16'h1234, 1'b0);
        bif.rob_br_retire = 1'b1;
        bif.rob_flush     = 1'b1;
        bif.exe_br_valid  = 1'b1;
        bif.exe_br_idx    = 4'd4;
        bif.exe_br_taken  = ~mq[1].pred;
        #1;
        chk("flush_ret_branch", 32'(bif.brq_ret_branch), 32'd1);
        step(); idle();
        chk("flush_empty", 32'(bif.brq_empty),      32'd1);
        chk("flush_tail",  32'(bif.brq_alloc_idx),  32'd0);
        chk("flush_mp",    32'(bif.brq_mispredict), 32'd0);

        random_cycles(400);

        for (int i = 0; i < 3; i++) begin
            alloc(16'($urandom), 1'($urandom));
            step();
        end
        idle();
        bif.rob_br_retire = 1'b1;
        rst = 1'b0;
        #1;
        chk("arst_empty",      32'(bif.brq_empty),      32'd1);
        chk("arst_full",       32'(bif.brq_full),       32'd0);
        chk("arst_alloc_idx",  32'(bif.brq_alloc_idx),  32'd0);
        chk("arst_head_ready", 32'(bif.brq_head_ready), 32'd0);
        chk("arst_ret_branch", 32'(bif.brq_ret_branch), 32'd0);
        chk("arst_mp",         32'(bif.brq_mispredict), 32'd0);
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        random_cycles(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
